expr_vector_sequencer: RTL and testbench

- Sequences operand vectors into a combinational expression datapath: the 12-operand a0..a5/b0..b5 evaluator with a 90-bit packed y result.
- Accepts one operand vector per valid/ready handshake, holds it stable on the datapath inputs for a programmable settle window, then captures y.
- Returns y with a vector index and folds every captured result into a running 32-bit signature, used for regression compare.
- Sits between the regression stimulus source and the datapath under test.

---
 rtl/expr_vector_sequencer.sv | 164 ++++++++++++++++
 tb/tb_expr_vector_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_vector_sequencer.sv
// expr_vector_sequencer
//
// Feeds operand vectors, one at a time, into a combinational expression
// datapath (12 operands a0..a5/b0..b5, 90-bit packed result). Each vector is
// held on dut_op for SETTLE cycles. The result is then captured, tagged with
// a running vector index, folded into a 32-bit signature and offered on a
// valid/ready output.
//
// Parameters:
//   SETTLE  cycles spent settling after operands are driven (0 allowed)
//   OP_W    packed operand width {a0..a5,b0..b5}
//   Y_W     datapath result width (fold below assumes 90 bits)
//   CNT_W   vector counter width
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high; discards any vector in flight
//   in_valid   operand vector valid
//   in_ready   sequencer can accept a vector (IDLE only)
//   in_op      packed operand vector
//   dut_op     registered operands driven to the datapath
//   dut_y      datapath result, combinational from dut_op
//   out_valid  captured result valid
//   out_ready  consumer accepts the result
//   out_y      captured result
//   out_idx    index of this vector
//   sig        running 32-bit signature
//   sig_clr    synchronous clear of sig and vector count
//   busy       high in any state except IDLE

module expr_vector_sequencer #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned OP_W   = 60,
    parameter int unsigned Y_W    = 90,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    output logic [OP_W-1:0]  dut_op,
    input  logic [Y_W-1:0]   dut_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Y_W-1:0]   out_y,
    output logic [CNT_W-1:0] out_idx,
    output logic [31:0]      sig,
    input  logic             sig_clr,
    output logic             busy
);

    // Wide enough to hold SETTLE itself (at least one bit when SETTLE is 0).
    localparam int unsigned SC_W = $clog2(SETTLE + 2);
    localparam logic [SC_W-1:0] SETTLE_LD = SC_W'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SC_W-1:0]  settle_cnt;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             capture;
    logic [31:0]      fold;

    // Signature contribution of one result: XOR of its 32-bit slices,
    // the top 26 bits zero-extended.
    assign fold = dut_y[31:0] ^ dut_y[63:32] ^ {6'b0, dut_y[89:64]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    // out_valid is decoded from state; it is high exactly while in OUT.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept = 1'b1;
                    if (SETTLE == 0) begin
                        state_nxt = S_CAPTURE;
                    end else begin
                        state_nxt = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                // Counter was loaded with SETTLE; leaving on 1 gives
                // exactly SETTLE cycles here.
                if (settle_cnt <= SC_W'(1)) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                capture   = 1'b1;
                state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dut_op     <= '0;
            settle_cnt <= '0;
            out_y      <= '0;
            out_idx    <= '0;
            count      <= '0;
            sig        <= '0;
        end else begin
            if (accept) begin
                dut_op     <= in_op;
                settle_cnt <= SETTLE_LD;
            end else if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt - SC_W'(1);
            end

            if (capture) begin
                out_y   <= dut_y;
                out_idx <= count;
            end

            // A clear coincident with capture wins for sig/count; out_idx
            // above still takes the pre-clear count.
            if (sig_clr) begin
                sig   <= '0;
                count <= '0;
            end else if (capture) begin
                sig   <= {sig[30:0], sig[31]} ^ fold;
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_expr_vector_sequencer.sv
`timescale 1ns/1ps
module tb_expr_vector_sequencer;

    localparam int NI = 3;   // 0: SETTLE=1,CNT_W=16  1: SETTLE=0,CNT_W=4  2: SETTLE=3,CNT_W=4

    function automatic int s_of(input int i);
        case (i)
            0: return 1;
            1: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int cw_of(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sig_clr;
    logic        out_ready;
    logic [59:0] in_op;
    logic [89:0] y_drv;
    logic        iv [NI];

    logic        rdy [NI];
    logic        ov  [NI];
    logic        bsy [NI];
    logic [59:0] dop [NI];
    logic [89:0] oy  [NI];
    logic [31:0] sg  [NI];
    logic [15:0] idx [NI];
    logic [15:0] idx0;
    logic [3:0]  idx1;
    logic [3:0]  idx2;

    assign idx[0] = idx0;
    assign idx[1] = {12'b0, idx1};
    assign idx[2] = {12'b0, idx2};

    expr_vector_sequencer #(.SETTLE(1), .OP_W(60), .Y_W(90), .CNT_W(16)) u_main (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy[0]), .in_op(in_op),
        .dut_op(dop[0]), .dut_y(y_drv), .out_valid(ov[0]), .out_ready(out_ready),
        .out_y(oy[0]), .out_idx(idx0), .sig(sg[0]), .sig_clr(sig_clr), .busy(bsy[0]));

    expr_vector_sequencer #(.SETTLE(0), .OP_W(60), .Y_W(90), .CNT_W(4)) u_s0 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy[1]), .in_op(in_op),
        .dut_op(dop[1]), .dut_y(y_drv), .out_valid(ov[1]), .out_ready(out_ready),
        .out_y(oy[1]), .out_idx(idx1), .sig(sg[1]), .sig_clr(sig_clr), .busy(bsy[1]));

    expr_vector_sequencer #(.SETTLE(3), .OP_W(60), .Y_W(90), .CNT_W(4)) u_s3 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(rdy[2]), .in_op(in_op),
        .dut_op(dop[2]), .dut_y(y_drv), .out_valid(ov[2]), .out_ready(out_ready),
        .out_y(oy[2]), .out_idx(idx2), .sig(sg[2]), .sig_clr(sig_clr), .busy(bsy[2]));

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit armed    = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // ---------------- transaction-level model ----------------
    // Each instance is either idle, waiting out its settle time (pend),
    // or holding a result (ov). Capture happens SETTLE+1 edges after accept.
    bit          m_pend [NI];
    bit          m_ov   [NI];
    int          m_wait [NI];
    logic [59:0] m_op   [NI];
    logic [89:0] m_y    [NI];
    logic [15:0] m_idx  [NI];
    logic [15:0] m_cnt  [NI];
    logic [31:0] m_sig  [NI];

    function automatic logic [31:0] fold_of(input logic [89:0] y);
        logic [31:0] hi;
        hi = 32'(y >> 64);
        return 32'(y) ^ 32'(y >> 32) ^ hi;
    endfunction

    function automatic logic [31:0] rotl1(input logic [31:0] s);
        return (s << 1) | (s >> 31);
    endfunction

    task automatic model_step(input int i);
        if (reset) begin
            m_pend[i] = 1'b0; m_ov[i] = 1'b0; m_wait[i] = 0;
            m_op[i] = '0; m_y[i] = '0; m_idx[i] = '0; m_cnt[i] = '0; m_sig[i] = '0;
        end else begin
            if (m_pend[i]) begin
                if (m_wait[i] == 0) begin
                    m_y[i]    = y_drv;
                    m_idx[i]  = m_cnt[i];
                    m_cnt[i]  = 16'((int'(m_cnt[i]) + 1) % (1 << cw_of(i)));
                    m_sig[i]  = rotl1(m_sig[i]) ^ fold_of(y_drv);
                    m_ov[i]   = 1'b1;
                    m_pend[i] = 1'b0;
                end else begin
                    m_wait[i] = m_wait[i] - 1;
                end
            end else if (m_ov[i]) begin
                if (out_ready) m_ov[i] = 1'b0;
            end else if (iv[i]) begin
                m_op[i]   = in_op;
                m_pend[i] = 1'b1;
                m_wait[i] = s_of(i);
            end
            if (sig_clr) begin
                m_sig[i] = '0;
                m_cnt[i] = '0;
            end
        end
    endtask

    // Single compare process: model advances on each edge, DUT sampled 1ns later.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int i = 0; i < NI; i++) model_step(i);
            #1;
            if (armed) begin
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("in_ready[%0d]", i), rdy[i], !(m_pend[i] || m_ov[i]));
                    chk($sformatf("busy[%0d]", i), bsy[i], (m_pend[i] || m_ov[i]));
                    chk($sformatf("out_valid[%0d]", i), ov[i], m_ov[i]);
                    chk($sformatf("dut_op[%0d]", i), dop[i], m_op[i]);
                    chk($sformatf("out_y[%0d]", i), oy[i], m_y[i]);
                    chk($sformatf("out_idx[%0d]", i), idx[i], m_idx[i]);
                    chk($sformatf("sig[%0d]", i), sg[i], m_sig[i]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input int i, input logic [59:0] op, input logic [89:0] y, output int t_acc);
        int n;
        @(negedge clk);
        in_op = op;
        y_drv = y;
        iv[i] = 1'b1;
        n = 0;
        while (rdy[i] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) tmo($sformatf("accept[%0d]", i));
        t_acc = cyc;
        @(negedge clk);
        iv[i] = 1'b0;
        chk($sformatf("dut_op_new[%0d]", i), dop[i], op);
    endtask

    task automatic wait_out(input int i, input int t_acc, output int lat);
        int n;
        n = 0;
        while (ov[i] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) tmo($sformatf("out_valid[%0d]", i));
        lat = cyc - t_acc;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        sig_clr = 1'b1;
        @(negedge clk);
        sig_clr = 1'b0;
    endtask

    initial begin
        int t;
        int lat;
        reset = 1'b1; sig_clr = 1'b0; out_ready = 1'b1;
        in_op = '0; y_drv = '0;
        for (int i = 0; i < NI; i++) iv[i] = 1'b0;

        @(negedge clk);
        armed = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", rdy[0], 1'b1);
        chk("rst_busy", bsy[0], 1'b0);
        chk("rst_out_valid", ov[0], 1'b0);
        chk("rst_sig", sg[0], 32'h0);

        // Single vector, SETTLE=1
        send(0, 60'h0123456789ABCDE, 90'h1, t);
        wait_out(0, t, lat);
        chk("lat_settle1", lat, 3);
        chk("v1_out_y", oy[0], 90'h1);
        chk("v1_out_idx", idx[0], 16'd0);
        chk("v1_sig", sg[0], 32'h1);
        @(negedge clk);
        chk("v1_in_ready_back", rdy[0], 1'b1);

        send(0, 60'h0FEDCBA98765432, 90'h1, t);
        wait_out(0, t, lat);
        chk("v2_out_idx", idx[0], 16'd1);
        chk("v2_sig", sg[0], 32'h3);

        // Fold from a cleared signature
        pulse_clr();
        send(0, 60'h111111111111111, {26'h3FFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, t);
        wait_out(0, t, lat);
        chk("fold_sig", sg[0], 32'h03FFFFFF);
        chk("fold_idx", idx[0], 16'd0);

        // Backpressure
        @(negedge clk);
        out_ready = 1'b0;
        send(0, 60'hABCDEF012345678, {26'h1234567, 32'hDEADBEEF, 32'hCAFEF00D}, t);
        wait_out(0, t, lat);
        in_op = 60'h999999999999999;
        iv[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", ov[0], 1'b1);
            chk("bp_out_y", oy[0], {26'h1234567, 32'hDEADBEEF, 32'hCAFEF00D});
            chk("bp_out_idx", idx[0], 16'd1);
            chk("bp_in_ready", rdy[0], 1'b0);
            chk("bp_dut_op", dop[0], 60'hABCDEF012345678);
        end
        out_ready = 1'b1;
        iv[0] = 1'b0;
        @(negedge clk);
        chk("bp_ready_back", rdy[0], 1'b1);
        chk("bp_valid_drop", ov[0], 1'b0);
        chk("bp_dut_op_kept", dop[0], 60'hABCDEF012345678);

        // Reset mid-SETTLE on the SETTLE=3 instance
        send(2, 60'h222222222222222, 90'h7, t);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("midrst_out_valid", ov[2], 1'b0);
        chk("midrst_sig", sg[2], 32'h0);
        chk("midrst_in_ready", rdy[2], 1'b1);
        chk("midrst_busy", bsy[2], 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_no_capture", ov[2], 1'b0);
        end

        // Latency for SETTLE=0 and SETTLE=3
        send(1, 60'h333333333333333, 90'h9, t);
        wait_out(1, t, lat);
        chk("lat_settle0", lat, 2);
        chk("s0_idx", idx[1], 16'd0);
        send(2, 60'h444444444444444, 90'hB, t);
        wait_out(2, t, lat);
        chk("lat_settle3", lat, 5);
        chk("s3_idx", idx[2], 16'd0);
        chk("s3_sig", sg[2], 32'hB);

        // Index wrap with a 4-bit counter
        pulse_clr();
        for (int k = 0; k < 17; k++) begin
            send(1, 60'(k + 16), 90'(k * 3 + 1), t);
            wait_out(1, t, lat);
            chk($sformatf("wrap_idx_%0d", k), idx[1], 16'(k % 16));
        end

        // sig_clr coincident with capture
        send(0, 60'h555555555555555, 90'h10, t);
        wait_out(0, t, lat);
        chk("clrA_idx", idx[0], 16'd0);
        chk("clrA_sig", sg[0], 32'h10);
        send(0, 60'h666666666666666, 90'h20, t);
        @(negedge clk);
        sig_clr = 1'b1;
        @(negedge clk);
        sig_clr = 1'b0;
        chk("clrB_valid", ov[0], 1'b1);
        chk("clrB_idx", idx[0], 16'd1);
        chk("clrB_sig", sg[0], 32'h0);
        chk("clrB_out_y", oy[0], 90'h20);
        send(0, 60'h777777777777777, 90'h5, t);
        wait_out(0, t, lat);
        chk("clrC_idx", idx[0], 16'd0);
        chk("clrC_sig", sg[0], 32'h5);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
